tiny16_uart_tx: RTL and testbench

Serial transmitter on the receiving end of the tiny16 core's 16-bit `OUT` port. It buffers output words written by the core in a small FIFO and transmits each word over a UART line as two 8N1 frames, low byte first. It sits between `tiny16` and the board TX pin, alongside `USBPU`, so the core's output can be observed on a host terminal.

---
 rtl/tiny16_pkg.sv | 9 +
 rtl/tiny16_fifo.sv | 48 ++++
 rtl/tiny16_uart_tx.sv | 108 ++++++++++
 tb/tb_tiny16_uart_tx.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/tiny16_pkg.sv
// tiny16_pkg: shared types and constants for the tiny16 peripherals.
//   uart_tx_state_t           - UART transmitter FSM states
//   UART_DATA_BITS            - data bits per UART frame
//   UART_DEFAULT_CLKS_PER_BIT - 16 MHz / 115200 baud
package tiny16_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
   localparam int UART_DATA_BITS = 8;
   localparam int UART_DEFAULT_CLKS_PER_BIT = 139;
endpackage

// File: rtl/tiny16_fifo.sv
// tiny16_fifo: synchronous FIFO with registered full flag.
//   clk_i, rst_i (async, active-high)
//   push_i/data_i - write; ignored while full_o is high
//   pop_i/data_o  - read; data_o shows the head word, ignored while empty_o
//   count_o       - occupancy, full_o, empty_o
module tiny16_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           data_i,
   output logic [WIDTH-1:0]           data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0] count_q, count_d;
   logic full_q, do_push, do_pop;
   assign do_push = push_i & ~full_q;
   assign do_pop  = pop_i & (count_q != '0);
   assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_q + AW'(do_push);
         rd_ptr_q <= rd_ptr_q + AW'(do_pop);
         count_q  <= count_d;
         full_q   <= count_d == (AW+1)'(DEPTH);
      end
   end
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = full_q;
   assign empty_o = count_q == '0;
endmodule

// File: rtl/tiny16_uart_tx.sv
// tiny16_uart_tx: buffers 16-bit OUT words and sends each as two UART frames, low byte first.
//   CLK, RST (async, active-high)
//   WR_EN/WR_DATA - word write strobe and data from the core
//   FULL          - FIFO full, writes dropped
//   BUSY          - frame on the line or words pending
//   TX            - serial line, idles high
// Define TINY16_UART_TX_PARITY_EN for 8E1 frames; otherwise frames are 8N1.
module tiny16_uart_tx
   import tiny16_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        WR_EN,
   input  logic [15:0] WR_DATA,
   output logic        FULL,
   output logic        BUSY,
   output logic        TX
);
   localparam int AW = $clog2(FIFO_DEPTH);
   uart_tx_state_t state_q, state_d;
   logic [15:0] timer_q, timer_d, hold_q, hold_d, fifo_data;
   logic [2:0] bit_q, bit_d;
   logic sel_q, sel_d, tx_q, tx_d, pop, fifo_empty, bit_done;
   logic [7:0] byte_d;
   logic [AW:0] fifo_cnt;
   tiny16_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (WR_EN),
      .pop_i   (pop),
      .data_i  (WR_DATA),
      .data_o  (fifo_data),
      .count_o (fifo_cnt),
      .full_o  (FULL),
      .empty_o (fifo_empty)
   );
   assign bit_done = timer_q == 16'(CLKS_PER_BIT-1);
   always_comb begin
      state_d = state_q;
      timer_d = (state_q == IDLE || bit_done) ? '0 : timer_q + 16'd1;
      bit_d   = bit_q;
      sel_d   = sel_q;
      hold_d  = hold_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: if (!fifo_empty) begin
            pop     = 1'b1;
            hold_d  = fifo_data;
            sel_d   = 1'b0;
            state_d = START;
         end
         START: if (bit_done) begin
            state_d = DATA;
            bit_d   = '0;
         end
         DATA: if (bit_done) begin
            bit_d = bit_q + 3'd1;
`ifdef TINY16_UART_TX_PARITY_EN
            if (bit_q == 3'(UART_DATA_BITS-1)) state_d = PARITY;
`else
            if (bit_q == 3'(UART_DATA_BITS-1)) state_d = STOP;
`endif
         end
`ifdef TINY16_UART_TX_PARITY_EN
         PARITY: if (bit_done) state_d = STOP;
`endif
         STOP: if (bit_done) begin
            // high byte follows with no gap; next word is popped straight into START
            if (!sel_q) begin
               sel_d   = 1'b1;
               state_d = START;
            end else if (!fifo_empty) begin
               pop     = 1'b1;
               hold_d  = fifo_data;
               sel_d   = 1'b0;
               state_d = START;
            end else state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // TX is registered, so its next value is derived from the next-state signals
      byte_d = sel_d ? hold_d[15:8] : hold_d[7:0];
      tx_d   = state_d == START ? 1'b0 : state_d == DATA ? byte_d[bit_d] :
               state_d == PARITY ? ^byte_d : 1'b1;
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         timer_q <= '0;
         bit_q   <= '0;
         sel_q   <= 1'b0;
         hold_q  <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         sel_q   <= sel_d;
         hold_q  <= hold_d;
         tx_q    <= tx_d;
      end
   end
   assign TX   = tx_q;
   assign BUSY = state_q != IDLE || fifo_cnt != '0;
endmodule

// File: tb/tb_tiny16_uart_tx.sv
// tb_tiny16_uart_tx: directed bench with a byte scoreboard and a cycle-accurate line receiver.
module tb_tiny16_uart_tx;
   localparam int CPB = 4;
`ifdef TINY16_UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;
   logic CLK = 0, RST = 0, WR_EN = 0;
   logic [15:0] WR_DATA = 0;
   logic FULL, BUSY, TX;
   int cyc = 0, checks = 0, errors = 0, frames_done = 0, acc = 0;
   logic [7:0] sb[$];
   int starts[$];
   tiny16_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
      .FULL(FULL), .BUSY(BUSY), .TX(TX)
   );
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // receiver: every cycle of a frame must hold its bit value
   initial begin
      int pos;
      logic act, ok, cur;
      logic [7:0] data, e;
      pos = 0; act = 0; ok = 1; cur = 1; data = 0;
      forever begin
         @(negedge CLK); #1;
         if (RST) act = 0;
         else if (act || TX === 1'b0) begin
            if (!act) begin
               act = 1; pos = 0; ok = 1;
               starts.push_back(cyc);
            end
            if (pos % CPB == 0) begin
               cur = TX;
               if (pos / CPB == 0) ok &= (TX === 1'b0);
               else if (pos / CPB <= 8) data[pos/CPB-1] = TX;
               else if (pos / CPB == NB-1) ok &= (TX === 1'b1);
               else ok &= (TX === ^data);
            end else if (TX !== cur) ok = 0;
            pos++;
            if (pos == FRAME) begin
               act = 0;
               e = 'x;
               if (sb.size() > 0) e = sb.pop_front();
               check("rx_byte", data, e);
               check("rx_frame", ok, 1);
               frames_done++;
            end
         end
      end
   end
   task automatic put(input logic [15:0] d, input bit accept);
      @(negedge CLK);
      WR_EN = 1; WR_DATA = d; acc = cyc + 1;
      if (accept) begin
         sb.push_back(d[7:0]);
         sb.push_back(d[15:8]);
      end
   endtask
   task automatic idle_in;
      @(negedge CLK);
      WR_EN = 0;
   endtask
   task automatic wait_done(input int n);
      int k = 0;
      while (frames_done < n && k < 1000) begin
         @(negedge CLK); #2;
         k++;
      end
      check("frames", frames_done, n);
   endtask
   task automatic restart;
      frames_done = 0;
      starts.delete();
   endtask
   task automatic word(input logic [15:0] d, input string tag);
      restart();
      put(d, 1);
      idle_in();
      wait_done(2);
      check({tag, "_lat"}, starts[0], acc + 1);
      check({tag, "_len"}, cyc - starts[0] + 1, 2 * FRAME);
      check({tag, "_busy_hi"}, BUSY, 1);
      @(negedge CLK); #2;
      check({tag, "_busy_lo"}, BUSY, 0);
      check({tag, "_tx_idle"}, TX, 1);
   endtask
   initial begin
      int first;
      logic bad;
      #1 RST = 1;
      #1;
      check("reset_tx", TX, 1);
      check("reset_full", FULL, 0);
      check("reset_busy", BUSY, 0);
      repeat (2) @(negedge CLK);
      RST = 0;
      bad = 0;
      repeat (20) begin
         @(negedge CLK);
         if (TX !== 1'b1 || FULL !== 1'b0 || BUSY !== 1'b0) bad = 1;
      end
      check("idle", bad, 0);
      word(16'h1234, "single");
      restart();
      put(16'hA55A, 1);
      first = acc;
      put(16'h00FF, 1);
      idle_in();
      wait_done(4);
      check("b2b_lat", starts[0], first + 1);
      for (int k = 0; k < 3; k++) check("b2b_gap", starts[k+1] - starts[k], FRAME);
      @(negedge CLK); #2;
      check("b2b_busy_lo", BUSY, 0);
      restart();
      first = 0;
      for (int i = 0; i < 6; i++) begin
         put(16'(i), i < 5);
         if (i == 0) first = acc;
         if (i == 4) check("ovf_full_pre", FULL, 0);
         if (i == 5) check("ovf_full", FULL, 1);
      end
      idle_in();
      check("ovf_full_hold", FULL, 1);
      while (cyc < first + 80) @(negedge CLK);
      check("ovf_full_before_pop", FULL, 1);
      @(negedge CLK);
      check("ovf_full_after_pop", FULL, 0);
      wait_done(10);
      check("ovf_span", starts[9] - starts[0], 9 * FRAME);
      check("ovf_sb_empty", sb.size(), 0);
      @(negedge CLK); #2;
      check("ovf_busy_lo", BUSY, 0);
      restart();
      put(16'h1234, 1);
      first = acc;
      idle_in();
      while (cyc < first + 11) @(negedge CLK);
      check("mid_tx_low", TX, 0);
      RST = 1;
      #1;
      check("mid_rst_tx", TX, 1);
      check("mid_rst_busy", BUSY, 0);
      check("mid_rst_full", FULL, 0);
      sb.delete();
      repeat (2) @(negedge CLK);
      RST = 0;
      word(16'h0001, "recover");
`ifdef TINY16_UART_TX_PARITY_EN
      word(16'h0701, "parity");
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
